// File: rtl/decoder_scan_ctrl.sv
// Select-code sequencer for a 4-to-16 line decoder: steps {e,x,y,z} through all
// 16 codes with a programmable dwell, single sweep or continuous, up or down.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | code static; load may preload it; start begins a scan
// RUN   | code advances every dwell+1 cycles; stop aborts
module decoder_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               load,
    input  logic [3:0]         load_val,
    output logic               e,
    output logic               x,
    output logic               y,
    output logic               z,
    output logic               busy,
    output logic               tick,
    output logic               done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [3:0]         code;
    logic [3:0]         next_code;
    logic [3:0]         step_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_lat;
    logic               mode_lat;
    logic               dir_lat;

    assign next_code = dir_lat ? (code - 4'd1) : (code + 4'd1);

    // code is a register, so the decoder select lines are glitch-free
    assign {e, x, y, z} = code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            code      <= 4'd0;
            step_cnt  <= 4'd0;
            dwell_cnt <= '0;
            dwell_lat <= '0;
            mode_lat  <= 1'b0;
            dir_lat   <= 1'b0;
            busy      <= 1'b0;
            tick      <= 1'b0;
            done      <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        code <= load_val;
                    end
                    if (start && !stop) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        mode_lat  <= mode;
                        dir_lat   <= dir;
                        dwell_lat <= dwell;
                        dwell_cnt <= dwell;
                        step_cnt  <= 4'd0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // abort wins over any advance or end-of-pass due now
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else if (step_cnt != 4'd15) begin
                        code      <= next_code;
                        step_cnt  <= step_cnt + 4'd1;
                        dwell_cnt <= dwell_lat;
                        tick      <= 1'b1;
                    end else if (!mode_lat) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        code      <= next_code;
                        step_cnt  <= 4'd0;
                        dwell_cnt <= dwell_lat;
                        tick      <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Randomized bench for decoder_scan_ctrl; expected outputs come from a
// closed-form model of the scan (code, busy, tick, done as a function of cycle).
module tb_decoder_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic       dir;
    logic [7:0] dwell;
    logic       load;
    logic [3:0] load_val;
    logic       e, x, y, z;
    logic       busy, tick, done;

    int total = 0;
    int bad   = 0;
    int cur_code = 0;

    decoder_scan_ctrl #(.DWELL_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .dir      (dir),
        .dwell    (dwell),
        .load     (load),
        .load_val (load_val),
        .e        (e),
        .x        (x),
        .y        (y),
        .z        (z),
        .busy     (busy),
        .tick     (tick),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input integer obs, input integer exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int ec, input int eb, input int et, input int ed);
        chk({tag, ".code"}, integer'({e, x, y, z}), ec);
        chk({tag, ".busy"}, integer'(busy), eb);
        chk({tag, ".tick"}, integer'(tick), et);
        chk({tag, ".done"}, integer'(done), ed);
    endtask

    // Starts a scan and checks ncyc cycles from the start edge; stop_at < 0 means no stop.
    task automatic run_scan(input string tag, input int org, input bit use_load, input bit dr,
                            input bit md, input int dw, input int ncyc, input int stop_at,
                            input bit disturb);
        int per;
        int len;
        int sgn;
        int ec, eb, et, ed;
        int frozen;
        per    = dw + 1;
        len    = 16 * per;
        sgn    = dr ? 15 : 1;
        frozen = 0;
        ec     = org;
        @(negedge clk);
        if (use_load) begin
            load     = 1'b1;
            load_val = 4'(org);
        end
        start = 1'b1;
        mode  = md;
        dir   = dr;
        dwell = 8'(dw);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        load  = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            if (stop_at >= 0 && k > stop_at) begin
                ec = frozen; eb = 0; et = 0; ed = 0;
            end else if (!md && k >= len) begin
                ec = (org + sgn * 15) % 16; eb = 0; et = 0; ed = (k == len) ? 1 : 0;
            end else begin
                ec = (org + sgn * (k / per)) % 16;
                eb = 1;
                et = (k > 0 && k % per == 0) ? 1 : 0;
                ed = (k > 0 && k % len == 0) ? 1 : 0;
            end
            if (k == stop_at) frozen = ec;
            chk_all(tag, ec, eb, et, ed);

            start = 1'b0;
            load  = 1'b0;
            stop  = 1'b0;
            if (disturb && k + 2 < len && (stop_at < 0 || k < stop_at)) begin
                start    = 1'($urandom);
                load     = 1'($urandom);
                load_val = 4'($urandom);
                dir      = 1'($urandom);
                mode     = 1'($urandom);
                dwell    = 8'($urandom);
            end
            if (k == stop_at) stop = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        start    = 1'b0;
        load     = 1'b0;
        stop     = 1'b0;
        cur_code = ec;
    endtask

    initial begin
        int md, dr, dw, ul, org, len, stop_at, ncyc;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        mode     = 1'b0;
        dir      = 1'b0;
        dwell    = 8'd0;
        load     = 1'b0;
        load_val = 4'd0;
        repeat (2) @(negedge clk);
        chk_all("in_reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_all("idle", 0, 0, 0, 0);
        end

        // one cycle per code, upward from 0
        run_scan("sweep_up_d0", 0, 1'b0, 1'b0, 1'b0, 0, 18, -1, 1'b0);
        // preload 5, down, three cycles per code
        run_scan("sweep_dn_d2", 5, 1'b1, 1'b1, 1'b0, 2, 50, -1, 1'b0);
        // continuous three passes from 0 then stop while code is 9
        run_scan("cont_stop", 0, 1'b1, 1'b0, 1'b1, 0, 60, 57, 1'b0);

        // start with stop in IDLE must not begin a scan
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk_all("start_stop_idle", cur_code, 0, 0, 0);
        @(negedge clk);
        chk_all("start_stop_idle2", cur_code, 0, 0, 0);

        // plain load in IDLE
        load     = 1'b1;
        load_val = 4'd11;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        chk_all("idle_load", 11, 0, 0, 0);
        cur_code = 11;

        // inputs wiggling during RUN must not disturb the scan
        run_scan("disturb", cur_code, 1'b0, 1'b1, 1'b0, 3, 66, -1, 1'b1);

        // maximum dwell
        run_scan("dwell_max", 7, 1'b1, 1'b0, 1'b0, 255, 16 * 256 + 2, -1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            md  = int'($urandom_range(0, 1));
            dr  = int'($urandom_range(0, 1));
            dw  = int'($urandom_range(0, 5));
            ul  = int'($urandom_range(0, 1));
            org = (ul != 0) ? int'($urandom_range(0, 15)) : cur_code;
            len = 16 * (dw + 1);
            if (md != 0) begin
                stop_at = int'($urandom_range(0, 2 * len));
                ncyc    = stop_at + 3;
            end else if ($urandom_range(0, 2) == 0) begin
                stop_at = int'($urandom_range(0, len - 1));
                ncyc    = stop_at + 3;
            end else begin
                stop_at = -1;
                ncyc    = len + 2;
            end
            run_scan("rand", org, ul != 0, dr != 0, md != 0, dw, ncyc, stop_at, 1'b1);
        end

        // asynchronous reset in the middle of a continuous scan
        run_scan("pre_reset", 3, 1'b1, 1'b0, 1'b1, 1, 10, -1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_all("post_reset", 0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
